// File: rtl/pong_frame_ctrl.sv
// -----------------------------------------------------------------------------
// pong_frame_ctrl
//   Frame-rate game sequencer for the Pong display path. Each accepted
//   frame_tick starts a three-step update (paddles -> ball/collisions ->
//   commit). All object coordinates, scores and the game state change together
//   on the commit cycle only, so the pixel renderer never sees a half-updated
//   frame.
//
// Ports
//   clk          pixel-domain clock
//   reset        asynchronous, active-low reset
//   frame_tick   one-cycle pulse at start of vertical blanking
//   start        restart request, honoured only in GAME_OVER
//   p1_up/down   left paddle buttons (level, already synchronised)
//   p2_up/down   right paddle buttons (level, already synchronised)
//   ball_x/y     ball top-left corner
//   paddle_l_y   left paddle top edge
//   paddle_r_y   right paddle top edge
//   score_l/r    scores
//   game_over    high while in GAME_OVER
//   update_done  one-cycle pulse when new coordinates are committed
// -----------------------------------------------------------------------------
module pong_frame_ctrl #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_XL    = 16,
    parameter int PADDLE_XR    = 616,
    parameter int BALL_SIZE    = 8,
    parameter int PADDLE_SPEED = 4,
    parameter int BALL_SPEED   = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       p1_up,
    input  logic       p1_down,
    input  logic       p2_up,
    input  logic       p2_down,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] paddle_l_y,
    output logic [9:0] paddle_r_y,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over,
    output logic       update_done
);

    localparam int CNT_W   = $clog2(SERVE_FRAMES + 1);
    localparam int PAD_MAX = V_ACTIVE - PADDLE_H;

    localparam logic [9:0] BALL_X0 = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] BALL_Y0 = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] PAD_Y0  = 10'(PAD_MAX / 2);

    // Signed 11-bit thresholds so that a step past the left/top edge is negative.
    localparam logic signed [10:0] ZERO_S  = '0;
    localparam logic signed [10:0] STEP_S  = 11'(BALL_SPEED);
    localparam logic signed [10:0] L_HIT_S = 11'(PADDLE_XL + PADDLE_W);
    localparam logic signed [10:0] R_HIT_S = 11'(PADDLE_XR - BALL_SIZE);
    localparam logic signed [10:0] X_MAX_S = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic signed [10:0] Y_MAX_S = 11'(V_ACTIVE - BALL_SIZE);

    typedef enum logic [1:0] {ST_SERVE, ST_PLAY, ST_POINT, ST_GAME_OVER} game_state_e;
    typedef enum logic [1:0] {PH_IDLE, PH_PADDLE, PH_BALL, PH_COMMIT} phase_e;

    phase_e           phase_q, phase_d;
    game_state_e      state_q, state_d;
    logic [9:0]       ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic [9:0]       pad_l_q, pad_l_d, pad_r_q, pad_r_d;
    logic [3:0]       score_l_q, score_l_d, score_r_q, score_r_d;
    logic [CNT_W-1:0] serve_cnt_q, serve_cnt_d;
    logic             dx_q, dx_d, dy_q, dy_d;         // 1 = +x / +y
    logic             point_left_q, point_left_d;     // scorer remembered across POINT
    logic             update_done_q, update_done_d;

    // Shadow copies built during the update and committed in one go.
    logic [9:0]       pad_l_sh_q, pad_l_sh_d, pad_r_sh_q, pad_r_sh_d;
    logic [9:0]       ball_x_sh_q, ball_x_sh_d, ball_y_sh_q, ball_y_sh_d;
    logic             dx_sh_q, dx_sh_d, dy_sh_q, dy_sh_d;
    logic             miss_sh_q, miss_sh_d;           // ball left the field this update
    logic             miss_left_sh_q, miss_left_sh_d; // 1 = left player scored

    logic signed [10:0] bx_s, by_s, nx, ny;
    logic [10:0]        by_u;
    logic               ov_l, ov_r;
    logic [3:0]         new_score;

    function automatic logic [9:0] paddle_step(input logic [9:0] y, input logic up, input logic dn);
        logic [9:0] r;
        r = y;
        if (up && !dn) begin
            r = (y < 10'(PADDLE_SPEED)) ? 10'd0 : y - 10'(PADDLE_SPEED);
        end else if (dn && !up) begin
            r = (y >= 10'(PAD_MAX - PADDLE_SPEED)) ? 10'(PAD_MAX) : y + 10'(PADDLE_SPEED);
        end
        return r;
    endfunction

    always_comb begin
        phase_d        = phase_q;
        state_d        = state_q;
        ball_x_d       = ball_x_q;
        ball_y_d       = ball_y_q;
        pad_l_d        = pad_l_q;
        pad_r_d        = pad_r_q;
        score_l_d      = score_l_q;
        score_r_d      = score_r_q;
        serve_cnt_d    = serve_cnt_q;
        dx_d           = dx_q;
        dy_d           = dy_q;
        point_left_d   = point_left_q;
        update_done_d  = 1'b0;
        pad_l_sh_d     = pad_l_sh_q;
        pad_r_sh_d     = pad_r_sh_q;
        ball_x_sh_d    = ball_x_sh_q;
        ball_y_sh_d    = ball_y_sh_q;
        dx_sh_d        = dx_sh_q;
        dy_sh_d        = dy_sh_q;
        miss_sh_d      = miss_sh_q;
        miss_left_sh_d = miss_left_sh_q;
        new_score      = point_left_q ? score_l_q + 4'd1 : score_r_q + 4'd1;

        bx_s = {1'b0, ball_x_q};
        by_s = {1'b0, ball_y_q};
        by_u = {1'b0, ball_y_q};
        nx   = dx_q ? bx_s + STEP_S : bx_s - STEP_S;
        ny   = dy_q ? by_s + STEP_S : by_s - STEP_S;
        // Overlap uses the paddle positions just computed for this same update.
        ov_l = (by_u + 11'(BALL_SIZE) > {1'b0, pad_l_sh_q}) &&
               (by_u < {1'b0, pad_l_sh_q} + 11'(PADDLE_H));
        ov_r = (by_u + 11'(BALL_SIZE) > {1'b0, pad_r_sh_q}) &&
               (by_u < {1'b0, pad_r_sh_q} + 11'(PADDLE_H));

        case (phase_q)
            PH_IDLE: begin
                if (frame_tick && state_q != ST_GAME_OVER) begin
                    phase_d = PH_PADDLE;
                end
            end
            PH_PADDLE: begin
                phase_d    = PH_BALL;
                pad_l_sh_d = pad_l_q;
                pad_r_sh_d = pad_r_q;
                if (state_q == ST_SERVE || state_q == ST_PLAY) begin
                    pad_l_sh_d = paddle_step(pad_l_q, p1_up, p1_down);
                    pad_r_sh_d = paddle_step(pad_r_q, p2_up, p2_down);
                end
            end
            PH_BALL: begin
                phase_d        = PH_COMMIT;
                ball_x_sh_d    = ball_x_q;
                ball_y_sh_d    = ball_y_q;
                dx_sh_d        = dx_q;
                dy_sh_d        = dy_q;
                miss_sh_d      = 1'b0;
                miss_left_sh_d = 1'b0;
                if (state_q == ST_PLAY) begin
                    if (ny <= ZERO_S) begin
                        ball_y_sh_d = 10'd0;
                        dy_sh_d     = 1'b1;
                    end else if (ny >= Y_MAX_S) begin
                        ball_y_sh_d = Y_MAX_S[9:0];
                        dy_sh_d     = 1'b0;
                    end else begin
                        ball_y_sh_d = ny[9:0];
                    end
                    // Paddle hit wins over a miss, which wins over a free move.
                    if (!dx_q && nx <= L_HIT_S && ov_l) begin
                        ball_x_sh_d = L_HIT_S[9:0];
                        dx_sh_d     = 1'b1;
                    end else if (dx_q && nx >= R_HIT_S && ov_r) begin
                        ball_x_sh_d = R_HIT_S[9:0];
                        dx_sh_d     = 1'b0;
                    end else if (nx <= ZERO_S) begin
                        ball_x_sh_d = 10'd0;
                        miss_sh_d   = 1'b1;
                    end else if (nx >= X_MAX_S) begin
                        ball_x_sh_d    = X_MAX_S[9:0];
                        miss_sh_d      = 1'b1;
                        miss_left_sh_d = 1'b1;
                    end else begin
                        ball_x_sh_d = nx[9:0];
                    end
                end
            end
            PH_COMMIT: begin
                phase_d       = PH_IDLE;
                update_done_d = 1'b1;
                pad_l_d       = pad_l_sh_q;
                pad_r_d       = pad_r_sh_q;
                ball_x_d      = ball_x_sh_q;
                ball_y_d      = ball_y_sh_q;
                dx_d          = dx_sh_q;
                dy_d          = dy_sh_q;
                case (state_q)
                    ST_SERVE: begin
                        if (serve_cnt_q == CNT_W'(SERVE_FRAMES - 1)) begin
                            state_d     = ST_PLAY;
                            serve_cnt_d = '0;
                        end else begin
                            serve_cnt_d = serve_cnt_q + 1'b1;
                        end
                    end
                    ST_PLAY: begin
                        if (miss_sh_q) begin
                            state_d      = ST_POINT;
                            point_left_d = miss_left_sh_q;
                        end
                    end
                    ST_POINT: begin
                        if (point_left_q) score_l_d = new_score;
                        else              score_r_d = new_score;
                        if (new_score == 4'(WIN_SCORE)) begin
                            state_d = ST_GAME_OVER;
                        end else begin
                            // Re-serve toward the player who just conceded.
                            state_d     = ST_SERVE;
                            serve_cnt_d = '0;
                            ball_x_d    = BALL_X0;
                            ball_y_d    = BALL_Y0;
                            dx_d        = point_left_q;
                        end
                    end
                    default: ;
                endcase
            end
            default: phase_d = PH_IDLE;
        endcase

        // Restart from GAME_OVER takes effect immediately; no update is in flight there.
        if (state_q == ST_GAME_OVER && start) begin
            phase_d       = PH_IDLE;
            state_d       = ST_SERVE;
            ball_x_d      = BALL_X0;
            ball_y_d      = BALL_Y0;
            pad_l_d       = PAD_Y0;
            pad_r_d       = PAD_Y0;
            score_l_d     = 4'd0;
            score_r_d     = 4'd0;
            serve_cnt_d   = '0;
            dx_d          = 1'b1;
            dy_d          = 1'b1;
            update_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q        <= PH_IDLE;
            state_q        <= ST_SERVE;
            ball_x_q       <= BALL_X0;
            ball_y_q       <= BALL_Y0;
            pad_l_q        <= PAD_Y0;
            pad_r_q        <= PAD_Y0;
            score_l_q      <= 4'd0;
            score_r_q      <= 4'd0;
            serve_cnt_q    <= '0;
            dx_q           <= 1'b1;
            dy_q           <= 1'b1;
            point_left_q   <= 1'b0;
            update_done_q  <= 1'b0;
            pad_l_sh_q     <= PAD_Y0;
            pad_r_sh_q     <= PAD_Y0;
            ball_x_sh_q    <= BALL_X0;
            ball_y_sh_q    <= BALL_Y0;
            dx_sh_q        <= 1'b1;
            dy_sh_q        <= 1'b1;
            miss_sh_q      <= 1'b0;
            miss_left_sh_q <= 1'b0;
        end else begin
            phase_q        <= phase_d;
            state_q        <= state_d;
            ball_x_q       <= ball_x_d;
            ball_y_q       <= ball_y_d;
            pad_l_q        <= pad_l_d;
            pad_r_q        <= pad_r_d;
            score_l_q      <= score_l_d;
            score_r_q      <= score_r_d;
            serve_cnt_q    <= serve_cnt_d;
            dx_q           <= dx_d;
            dy_q           <= dy_d;
            point_left_q   <= point_left_d;
            update_done_q  <= update_done_d;
            pad_l_sh_q     <= pad_l_sh_d;
            pad_r_sh_q     <= pad_r_sh_d;
            ball_x_sh_q    <= ball_x_sh_d;
            ball_y_sh_q    <= ball_y_sh_d;
            dx_sh_q        <= dx_sh_d;
            dy_sh_q        <= dy_sh_d;
            miss_sh_q      <= miss_sh_d;
            miss_left_sh_q <= miss_left_sh_d;
        end
    end

    assign ball_x      = ball_x_q;
    assign ball_y      = ball_y_q;
    assign paddle_l_y  = pad_l_q;
    assign paddle_r_y  = pad_r_q;
    assign score_l     = score_l_q;
    assign score_r     = score_r_q;
    assign game_over   = (state_q == ST_GAME_OVER);
    assign update_done = update_done_q;

endmodule

// File: tb/tb_pong_frame_ctrl.sv
module tb_pong_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0, start = 1'b0;
    logic       p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
    logic [9:0] ball_x, ball_y, paddle_l_y, paddle_r_y;
    logic [3:0] score_l, score_r;
    logic       game_over, update_done;

    pong_frame_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
        .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
        .ball_x(ball_x), .ball_y(ball_y), .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
        .score_l(score_l), .score_r(score_r), .game_over(game_over), .update_done(update_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int bx, by, pl, pr, sl, sr;
        bit go;
        bit done;
    } exp_t;
    exp_t exp_q[$];

    // Behavioural game model: st 0=SERVE 1=PLAY 2=POINT 3=GAME_OVER
    int m_bx, m_by, m_pl, m_pr, m_sl, m_sr, m_st, m_cnt;
    bit m_dx, m_dy, m_ptl;
    // Button policies: 0 none, 1 up, 2 down, 3 both, 4 track ball, 5 avoid ball
    int p1_mode = 0, p2_mode = 0;
    bit p1_far = 0, p2_far = 0;

    function automatic void model_reset();
        m_bx = 316; m_by = 236; m_pl = 208; m_pr = 208;
        m_sl = 0; m_sr = 0; m_st = 0; m_cnt = 0;
        m_dx = 1; m_dy = 1; m_ptl = 0;
    endfunction

    function automatic int pstep(int y, bit u, bit d);
        if (u && !d) return (y < 4) ? 0 : y - 4;
        if (d && !u) return (y >= 412) ? 416 : y + 4;
        return y;
    endfunction

    function automatic bit model_step(bit u1, bit d1, bit u2, bit d2);
        int nx, ny;
        bit ovl, ovr;
        if (m_st == 3) return 0;
        if (m_st <= 1) begin
            m_pl = pstep(m_pl, u1, d1);
            m_pr = pstep(m_pr, u2, d2);
        end
        case (m_st)
            0: begin
                if (m_cnt == 59) begin m_st = 1; m_cnt = 0; end
                else m_cnt++;
            end
            1: begin
                nx  = m_dx ? m_bx + 2 : m_bx - 2;
                ny  = m_dy ? m_by + 2 : m_by - 2;
                ovl = (m_by + 8 > m_pl) && (m_by < m_pl + 64);
                ovr = (m_by + 8 > m_pr) && (m_by < m_pr + 64);
                if (ny <= 0) begin m_by = 0; m_dy = 1; end
                else if (ny >= 472) begin m_by = 472; m_dy = 0; end
                else m_by = ny;
                if (!m_dx && nx <= 24 && ovl) begin m_bx = 24; m_dx = 1; end
                else if (m_dx && nx + 8 >= 616 && ovr) begin m_bx = 608; m_dx = 0; end
                else if (nx <= 0) begin m_bx = 0; m_st = 2; m_ptl = 0; end
                else if (nx >= 632) begin m_bx = 632; m_st = 2; m_ptl = 1; end
                else m_bx = nx;
            end
            2: begin
                if (m_ptl) m_sl++; else m_sr++;
                if ((m_ptl ? m_sl : m_sr) == 9) m_st = 3;
                else begin
                    m_st = 0; m_cnt = 0; m_bx = 316; m_by = 236; m_dx = m_ptl;
                end
            end
            default: ;
        endcase
        return 1;
    endfunction

    function automatic void policy(int mode, int pad, inout bit far, output bit u, output bit d);
        u = 0; d = 0;
        case (mode)
            1: u = 1;
            2: d = 1;
            3: begin u = 1; d = 1; end
            4: begin
                if (pad > m_by - 28 + 4) u = 1;
                else if (pad < m_by - 28 - 4) d = 1;
            end
            5: begin
                if (m_by < 200) far = 1;
                else if (m_by > 272) far = 0;
                if (far) d = 1; else u = 1;
            end
            default: ;
        endcase
    endfunction

    // Drive one frame_tick, push the model's prediction, then pop and compare
    // once the DUT reports (or, in GAME_OVER, does not report) a commit.
    task automatic run_frame();
        bit u1, d1, u2, d2, got;
        int lat, n_done;
        exp_t e;
        policy(p1_mode, m_pl, p1_far, u1, d1);
        policy(p2_mode, m_pr, p2_far, u2, d2);
        @(negedge clk);
        p1_up = u1; p1_down = d1; p2_up = u2; p2_down = d2;
        frame_tick = 1'b1;
        e.done = model_step(u1, d1, u2, d2);
        e.bx = m_bx; e.by = m_by; e.pl = m_pl; e.pr = m_pr;
        e.sl = m_sl; e.sr = m_sr; e.go = (m_st == 3);
        exp_q.push_back(e);
        @(negedge clk);
        frame_tick = 1'b0;
        got = 0; lat = 0; n_done = 0;
        for (int i = 2; i <= 8; i++) begin
            @(negedge clk);
            if (update_done === 1'b1) begin
                n_done++;
                if (!got) begin got = 1; lat = i; end
            end
        end
        e = exp_q.pop_front();
        total++;
        if (e.done && (n_done != 1 || lat != 4)) begin
            bad++;
            $display("FAIL update_done_timing: got pulses=%0d at_cycle=%0d want pulses=1 at_cycle=4", n_done, lat);
        end else if (!e.done && n_done != 0) begin
            bad++;
            $display("FAIL update_done_frozen: got pulses=%0d want 0", n_done);
        end
        total++;
        if (ball_x !== 10'(e.bx) || ball_y !== 10'(e.by) || paddle_l_y !== 10'(e.pl) ||
            paddle_r_y !== 10'(e.pr) || score_l !== 4'(e.sl) || score_r !== 4'(e.sr) ||
            game_over !== e.go) begin
            bad++;
            $display("FAIL frame_state: got bx=%0d by=%0d pl=%0d pr=%0d sl=%0d sr=%0d go=%0b want bx=%0d by=%0d pl=%0d pr=%0d sl=%0d sr=%0d go=%0b",
                     ball_x, ball_y, paddle_l_y, paddle_r_y, score_l, score_r, game_over,
                     e.bx, e.by, e.pl, e.pr, e.sl, e.sr, e.go);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0; frame_tick = 1'b0; start = 1'b0;
        p1_up = 0; p1_down = 0; p2_up = 0; p2_down = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
        exp_q.delete();
    endtask

    task automatic check_centre(input string name);
        total++;
        if (ball_x !== 10'd316 || ball_y !== 10'd236 || paddle_l_y !== 10'd208 ||
            paddle_r_y !== 10'd208 || score_l !== 4'd0 || score_r !== 4'd0 ||
            game_over !== 1'b0 || update_done !== 1'b0) begin
            bad++;
            $display("FAIL %s: got bx=%0d by=%0d pl=%0d pr=%0d sl=%0d sr=%0d go=%0b ud=%0b want 316 236 208 208 0 0 0 0",
                     name, ball_x, ball_y, paddle_l_y, paddle_r_y, score_l, score_r, game_over, update_done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_centre("reset_values");
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        check_centre("after_release");
    endtask

    task automatic test_first_frame();
        p1_mode = 0; p2_mode = 0;
        run_frame();
        total++;
        if (ball_x !== 10'd316 || paddle_l_y !== 10'd208) begin
            bad++;
            $display("FAIL first_frame: got bx=%0d pl=%0d want 316 208", ball_x, paddle_l_y);
        end
    endtask

    task automatic test_paddle_up();
        apply_reset();
        p1_mode = 1;
        for (int f = 1; f <= 60; f++) begin
            run_frame();
            if (f == 51 || f == 52 || f == 60) begin
                total++;
                if (paddle_l_y !== ((f == 51) ? 10'd4 : 10'd0)) begin
                    bad++;
                    $display("FAIL paddle_up_f%0d: got %0d want %0d", f, paddle_l_y, (f == 51) ? 4 : 0);
                end
            end
        end
        p1_mode = 2;
        run_frame();
        total++;
        if (paddle_l_y !== 10'd4 || ball_x !== 10'd318 || ball_y !== 10'd238) begin
            bad++;
            $display("FAIL first_play: got pl=%0d bx=%0d by=%0d want 4 318 238", paddle_l_y, ball_x, ball_y);
        end
        p1_mode = 3;
        run_frame();
        total++;
        if (paddle_l_y !== 10'd4) begin
            bad++;
            $display("FAIL paddle_both: got %0d want 4", paddle_l_y);
        end
    endtask

    task automatic test_wall_bounce();
        bit found = 0;
        p1_mode = 0; p2_mode = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            run_frame();
            if (ball_y === 10'd472) found = 1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL wall_reach: got no ball_y=472 want 472 within 300 frames");
        end
        run_frame();
        total++;
        if (ball_y !== 10'd470) begin
            bad++;
            $display("FAIL wall_bounce: got %0d want 470", ball_y);
        end
    endtask

    task automatic test_paddle_hit();
        bit found = 0;
        p1_mode = 4; p2_mode = 4;
        for (int i = 0; i < 3000 && !found; i++) begin
            run_frame();
            if (m_bx == 26 && !m_dx && m_st == 1) found = 1;
        end
        total++;
        if (!found || ball_x !== 10'd26) begin
            bad++;
            $display("FAIL hit_approach: got found=%0b bx=%0d want found=1 bx=26", found, ball_x);
        end
        run_frame();
        total++;
        if (ball_x !== 10'd24) begin
            bad++;
            $display("FAIL left_hit: got %0d want 24", ball_x);
        end
        run_frame();
        total++;
        if (ball_x !== 10'd26) begin
            bad++;
            $display("FAIL after_hit: got %0d want 26", ball_x);
        end
    endtask

    task automatic test_miss();
        int old_sr = m_sr;
        p1_mode = 5; p2_mode = 4;
        for (int i = 0; i < 1500 && m_sr == old_sr; i++) run_frame();
        total++;
        if (score_r !== 4'(old_sr + 1) || ball_x !== 10'd316 || ball_y !== 10'd236) begin
            bad++;
            $display("FAIL left_miss: got sr=%0d bx=%0d by=%0d want sr=%0d bx=316 by=236",
                     score_r, ball_x, ball_y, old_sr + 1);
        end
        run_frame();
        total++;
        if (ball_x !== 10'd316) begin
            bad++;
            $display("FAIL serve_hold: got %0d want 316", ball_x);
        end
    endtask

    task automatic test_game_over();
        p1_mode = 4; p2_mode = 5;
        for (int i = 0; i < 6000 && m_st != 3; i++) run_frame();
        total++;
        if (game_over !== 1'b1 || score_l !== 4'd9) begin
            bad++;
            $display("FAIL game_over: got go=%0b sl=%0d want go=1 sl=9", game_over, score_l);
        end
        repeat (3) run_frame();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_reset();
        check_centre("restart");
        run_frame();
    endtask

    task automatic test_start_ignored();
        p1_mode = 2; p2_mode = 0;
        run_frame();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (paddle_l_y !== 10'd212) begin
            bad++;
            $display("FAIL start_ignored: got pl=%0d want 212", paddle_l_y);
        end
        run_frame();
    endtask

    task automatic test_back_to_back();
        int n_done = 0;
        exp_t e;
        p1_mode = 0; p2_mode = 0;
        @(negedge clk);
        p1_up = 0; p1_down = 1; p2_up = 0; p2_down = 0;
        frame_tick = 1'b1;
        e.done = model_step(0, 1, 0, 0);
        e.bx = m_bx; e.by = m_by; e.pl = m_pl; e.pr = m_pr;
        e.sl = m_sl; e.sr = m_sr; e.go = (m_st == 3);
        exp_q.push_back(e);
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (update_done === 1'b1) n_done++;
        end
        e = exp_q.pop_front();
        total++;
        if (n_done != 1 || paddle_l_y !== 10'(e.pl)) begin
            bad++;
            $display("FAIL back_to_back: got pulses=%0d pl=%0d want pulses=1 pl=%0d", n_done, paddle_l_y, e.pl);
        end
        p1_down = 0;
    endtask

    task automatic test_reset_mid();
        int n_done = 0;
        @(negedge clk);
        p1_down = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_centre("reset_mid_update");
        @(negedge clk);
        reset = 1'b1;
        p1_down = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (update_done === 1'b1) n_done++;
        end
        total++;
        if (n_done != 0) begin
            bad++;
            $display("FAIL reset_abort: got pulses=%0d want 0", n_done);
        end
        check_centre("reset_mid_after");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_frame();
        test_paddle_up();
        test_wall_bounce();
        test_paddle_hit();
        test_miss();
        test_game_over();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pong_frame_ctrl.md
# pong_frame_ctrl

Frame-rate game sequencer for the Pong display path. On each frame boundary from `vga_ctrl` it runs a 3-cycle update of paddle positions, ball motion, collisions and scoring, then commits all object coordinates at once. The pixel renderer feeding `vga_ctrl` reads these coordinates, so they never change during active video.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines
- PADDLE_W, 8, paddle width in px
- PADDLE_H, 64, paddle height in px
- PADDLE_XL, 16, left paddle left edge x
- PADDLE_XR, 616, right paddle left edge x
- BALL_SIZE, 8, ball side in px
- PADDLE_SPEED, 4, paddle px per frame
- BALL_SPEED, 2, ball px per frame per axis
- SERVE_FRAMES, 60, frames held in SERVE
- WIN_SCORE, 9, score that ends the game

Ports:
- clk  in  1  pixel-domain clock
- reset  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse at start of vertical blanking (from vga_ctrl)
- start  in  1  restart request, used only in GAME_OVER
- p1_up, p1_down, p2_up, p2_down  in  1 each  level buttons, already synchronised upstream
- ball_x, ball_y  out  10 each  ball top-left corner
- paddle_l_y, paddle_r_y  out  10 each  paddle top edges
- score_l, score_r  out  4 each  scores
- game_over  out  1  high while in GAME_OVER
- update_done  out  1  one-cycle pulse when new coordinates are committed

## Operation
- Reset values:
  - ball_x=316, ball_y=236
  - paddle_l_y=paddle_r_y=208
  - scores 0, game_over=0, update_done=0
  - state SERVE, serve counter 0
  - ball direction dx=+, dy=+
- States:
  - SERVE: ball held at centre; count frames; after SERVE_FRAMES frames -> PLAY.
  - PLAY: paddles and ball move.
  - POINT: one update; increment scorer's score; if it equals WIN_SCORE -> GAME_OVER, else SERVE with ball re-centred and dx pointing toward the player who conceded.
  - GAME_OVER: all outputs frozen; a start pulse clears scores, centres all objects and goes to SERVE; start is ignored in every other state.
- Paddles move in SERVE and PLAY:
  - up: y -= PADDLE_SPEED, saturating at 0.
  - down: y += PADDLE_SPEED, saturating at V_ACTIVE-PADDLE_H (416).
  - up and down together: no move.
- Ball, PLAY only, using 11-bit signed intermediates: nx = x ± BALL_SPEED, ny = y ± BALL_SPEED.
- Walls: ny ≤ 0 -> y=0, dy=+. ny ≥ V_ACTIVE-BALL_SIZE (472) -> y=472, dy=-.
- Overlap test: ball overlaps a paddle vertically when ball_y+BALL_SIZE > pad_y and ball_y < pad_y+PADDLE_H.
- Left paddle hit: dx=- and nx ≤ PADDLE_XL+PADDLE_W (24) with overlap -> x=24, dx=+.
- Right paddle hit: dx=+ and nx+BALL_SIZE ≥ PADDLE_XR with overlap -> x=608, dx=-.
- Miss: nx ≤ 0 -> POINT for right player. nx ≥ H_ACTIVE-BALL_SIZE -> POINT for left player. Ball is clamped at the edge for that frame.
- Priority per update: paddle hit > miss > free move. Wall bounce is applied to y independently of x.
- Overlap tests use the newly committed paddle positions from the same update.

## Timing
- frame_tick seen at cycle T:
  - T+1: new paddle positions computed into shadow registers.
  - T+2: ball tentative position and collision decision.
  - T+3: all outputs and state commit together; update_done=1 for this cycle only.
- Outputs are stable at all other times.
- frame_tick arriving while an update is in flight (T+1..T+3) is ignored.
- The SERVE counter advances once per completed update.
- reset asserted mid-update aborts it. Outputs return to reset values asynchronously; update_done=0.

## Test plan
- Reset, then 1 frame_tick with no buttons -> update_done at T+3; ball (316,236), paddles 208, still SERVE.
- Hold p1_up for 60 frames from reset -> paddle_l_y decreases by 4 per frame, reaches 0 at frame 52, then stays 0. p1_up+p1_down together -> no change.
- After 60 frames ball moves +2,+2 per frame; ball_y reaches 472 -> dy flips, next frame ball_y=470.
- Ball at x=26, dx=-, paddle_l_y aligned with ball -> x=24, dx=+. Same case with paddle moved away -> ball exits left, score_r increments, ball re-centred, SERVE.
- Drive score_l to 9 -> game_over=1 and outputs frozen across further frame_ticks. start -> scores 0, game_over=0, SERVE.
- Two frame_ticks 2 cycles apart -> exactly one update_done. Reset at T+2 -> no commit, outputs at reset values.
